bg_write_arbiter: RTL
=====================

BG_WRITE_ARBITER -- requirements
Module: bg_write_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 6, number of background-RAM write requesters.
REQ-002 SHALL have parameter TILE_COLS, default 40, tile columns per row.
REQ-003 SHALL have parameter TILE_ROWS, default 30, tile rows per frame; NUM_TILES = TILE_COLS*TILE_ROWS = 1200.
REQ-004 SHALL have port clk  in  1  system clock; the only clock.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port req  in  N_REQ  per-requester write request, level.
REQ-007 SHALL have port req_addr  in  N_REQ*16  packed tile addresses; requester i uses bits [16i+15:16i].
REQ-008 SHALL have port req_data  in  N_REQ*32  packed tile attribute words; requester i uses bits [32i+31:32i].
REQ-009 SHALL have port clear_start  in  1  one-cycle pulse that requests a full background clear.
REQ-010 SHALL have port gnt  out  N_REQ  one-hot, one-cycle acceptance pulse.
REQ-011 SHALL have port bg_wea  out  1  background RAM write enable.
REQ-012 SHALL have port bg_ram_addr  out  16  background RAM write address.
REQ-013 SHALL have port bg_ram_data  out  32  background RAM write data.
REQ-014 SHALL have port clear_busy  out  1  high while the clear sweep runs.
REQ-015 SHALL have port clear_done  out  1  one-cycle pulse at the end of a sweep.
REQ-016 SHALL have port addr_err  out  1  sticky flag for an out-of-range request address.

Function
REQ-017 SHALL drive all outputs from registers; write latency is 1 cycle, from the sampling edge to bg_wea/addr/data/gnt being valid.
REQ-018 SHALL implement an FSM with states IDLE, ARB and CLEAR.
- IDLE -> ARB when any req bit is high.
- IDLE or ARB -> CLEAR on clear_start.
- ARB -> IDLE when no eligible req remains.
- CLEAR -> IDLE after the last clear write.
REQ-019 SHALL arbitrate in ARB round-robin.
- Winner = first eligible req at index >= ptr, wrapping modulo N_REQ.
- On each grant, ptr <= winner+1, wrapping N_REQ-1 -> 0.
- ptr = 0 after reset.
REQ-020 SHALL treat the requester granted on the previous cycle as ineligible on the current cycle, so a held req is never double-granted.
- A single requester therefore gets at most one write every two cycles.
- Two or more requesters get one write per cycle combined.
REQ-021 SHALL follow these handshake rules:
- A requester holds req, addr and data stable until it sees gnt.
- It deasserts req or presents new data on the next edge.
- Dropping req before gnt is legal and produces no write.
REQ-022 SHALL, on a grant to an in-range address (addr < NUM_TILES), assert bg_wea=1 and gnt[winner]=1 for exactly one cycle, with the sampled addr/data.
REQ-023 SHALL, on a grant to an out-of-range address (addr >= NUM_TILES), pulse gnt[winner], hold bg_wea=0 and set addr_err=1; addr_err clears only on reset.
REQ-024 SHALL run the CLEAR sweep as follows:
- Write addresses 0..NUM_TILES-1 in increasing order, data 0, bg_wea=1, one per cycle, 1200 consecutive cycles.
- clear_busy is high from the first sweep write through the last.
- clear_done pulses on the cycle after the last write.
REQ-025 SHALL hold gnt at zero during CLEAR; pending requests wait and are arbitrated in ARB after the sweep, with ptr unchanged.
REQ-026 SHALL ignore clear_start while CLEAR is active, with no restart and no extension.
REQ-027 SHALL give clear_start priority over any req sampled on the same edge.
REQ-028 SHALL drive bg_wea=0 and gnt=0 on any idle cycle; bg_ram_addr/bg_ram_data hold their last value.

Reset
REQ-029 SHALL, on reset=1 at a clock edge, set:
- state to IDLE, ptr to 0, the previous-winner mask to none, and the clear counter to 0;
- gnt, bg_wea, bg_ram_addr, bg_ram_data, clear_busy, clear_done and addr_err all to 0.
REQ-030 SHALL abort a sweep on reset mid-CLEAR with no clear_done pulse; addresses not yet written keep their old RAM contents.

Structure
REQ-031 SHALL take TILE_COLS, TILE_ROWS, NUM_TILES, the 16-bit address width, the 32-bit data width and the FSM state enum from shared package bg_pkg.
REQ-032 SHALL implement round-robin selection in one sub-module rr_picker.
- Inputs: eligible vector and ptr.
- Outputs: one-hot winner and valid.
- Purely combinational.

Verification
REQ-033 SHALL cover a single requester:
- Stimulus: req[2]=1 held for 10 cycles, addr 0x0064, data 0x1A5.
- Required response: bg_wea=1 with addr 0x0064 and data 0x1A5 on alternate cycles only; gnt[2] pulses 5 times.
REQ-034 SHALL cover all requesters contending:
- Stimulus: all 6 req held high from reset.
- Required response: grant order 0,1,2,3,4,5,0 with one write per cycle and no gaps.
REQ-035 SHALL cover a clear with pending requests:
- Stimulus: clear_start with req[1] pending.
- Required response: 1200 writes, addr 0..1199 with data 0, and gnt=0 throughout; clear_done on cycle 1201; gnt[1] issued after the sweep.
REQ-036 SHALL cover an out-of-range address:
- Stimulus: req[4] with addr 1200.
- Required response: gnt[4] pulses, bg_wea stays 0, addr_err=1 stays set until reset.
REQ-037 SHALL cover reset mid-sweep:
- Stimulus: reset at sweep address 500.
- Required response: all outputs 0 on the next cycle, no clear_done; a following clear_start restarts the sweep at address 0.

Source files
------------

// File: rtl/bg_pkg.sv
// Shared constants and FSM state type for the background-RAM write path.
package bg_pkg;
  localparam int TILE_COLS = 40;
  localparam int TILE_ROWS = 30;
  localparam int NUM_TILES = TILE_COLS * TILE_ROWS;
  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    CLEAR = 2'd2
  } bg_state_t;
endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first eligible index at or after ptr, wrapping.
module rr_picker #(
  parameter int N  = 6,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  eligible,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic          valid
);
  logic [PW-1:0] idx;

  // Scan from farthest to nearest so the nearest eligible index is written last.
  always_comb begin
    winner = '0;
    idx    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % N);
      if (eligible[idx]) begin
        winner      = '0;
        winner[idx] = 1'b1;
      end
    end
    valid = |eligible;
  end
endmodule

// File: rtl/bg_write_arbiter.sv
// Round-robin arbiter for background tile-RAM writes with a full-frame clear sweep.
// state | meaning: IDLE no activity | ARB granting requests | CLEAR zero-fill sweep running
module bg_write_arbiter #(
  parameter int N_REQ     = 6,
  parameter int TILE_COLS = bg_pkg::TILE_COLS,
  parameter int TILE_ROWS = bg_pkg::TILE_ROWS
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [N_REQ-1:0]                 req,
  input  logic [N_REQ*bg_pkg::ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*bg_pkg::DATA_W-1:0]  req_data,
  input  logic                             clear_start,
  output logic [N_REQ-1:0]                 gnt,
  output logic                             bg_wea,
  output logic [bg_pkg::ADDR_W-1:0]        bg_ram_addr,
  output logic [bg_pkg::DATA_W-1:0]        bg_ram_data,
  output logic                             clear_busy,
  output logic                             clear_done,
  output logic                             addr_err
);
  import bg_pkg::*;

  localparam int PW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int N_TILES = TILE_COLS * TILE_ROWS;
  localparam logic [ADDR_W-1:0] N_TILES_A = ADDR_W'(N_TILES);

  bg_state_t         state, state_n;
  logic [PW-1:0]     ptr, ptr_n;
  logic [N_REQ-1:0]  prev_win, prev_n;
  logic [ADDR_W-1:0] clr_cnt, clr_n;
  logic [N_REQ-1:0]  gnt_n;
  logic              wea_n, busy_n, done_n, err_n;
  logic [ADDR_W-1:0] addr_n, win_addr;
  logic [DATA_W-1:0] data_n, win_data;
  logic [N_REQ-1:0]  eligible, winner;
  logic              valid;
  logic [PW-1:0]     win_idx;

  // Last cycle's winner sits out one cycle so a held req is not granted twice.
  assign eligible = req & ~prev_win;

  rr_picker #(.N(N_REQ), .PW(PW)) u_picker (
    .eligible (eligible),
    .ptr      (ptr),
    .winner   (winner),
    .valid    (valid)
  );

  always_comb begin
    win_idx  = '0;
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner[i]) begin
        win_idx  = PW'(i);
        win_addr = req_addr[ADDR_W*i +: ADDR_W];
        win_data = req_data[DATA_W*i +: DATA_W];
      end
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    prev_n  = '0;
    clr_n   = clr_cnt;
    gnt_n   = '0;
    wea_n   = 1'b0;
    addr_n  = bg_ram_addr;
    data_n  = bg_ram_data;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    err_n   = addr_err;
    case (state)
      CLEAR: begin
        if (clr_cnt == N_TILES_A) begin
          done_n  = 1'b1;
          clr_n   = '0;
          state_n = IDLE;
        end else begin
          wea_n  = 1'b1;
          addr_n = clr_cnt;
          data_n = '0;
          busy_n = 1'b1;
          clr_n  = clr_cnt + 1'b1;
        end
      end
      default: begin
        if (clear_start) begin
          // Address 0 is written on the accepting edge; the counter holds the next address.
          state_n = CLEAR;
          wea_n   = 1'b1;
          addr_n  = '0;
          data_n  = '0;
          busy_n  = 1'b1;
          clr_n   = ADDR_W'(1);
        end else if (valid) begin
          state_n = ARB;
          gnt_n   = winner;
          prev_n  = winner;
          ptr_n   = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
          if (win_addr < N_TILES_A) begin
            wea_n  = 1'b1;
            addr_n = win_addr;
            data_n = win_data;
          end else begin
            err_n = 1'b1;
          end
        end else begin
          state_n = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      prev_win    <= '0;
      clr_cnt     <= '0;
      gnt         <= '0;
      bg_wea      <= 1'b0;
      bg_ram_addr <= '0;
      bg_ram_data <= '0;
      clear_busy  <= 1'b0;
      clear_done  <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      prev_win    <= prev_n;
      clr_cnt     <= clr_n;
      gnt         <= gnt_n;
      bg_wea      <= wea_n;
      bg_ram_addr <= addr_n;
      bg_ram_data <= data_n;
      clear_busy  <= busy_n;
      clear_done  <= done_n;
      addr_err    <= err_n;
    end
  end
endmodule
